// File: rtl/spi_reg_ctrl_if.sv
// Byte-level handshake between spi_device and the register controller.
// Signal suffixes are named from the controller's point of view.
interface spi_reg_ctrl_if;
    logic       ssn_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] tx_data_o;
    logic       tx_load_o;

    modport slave (
        input  ssn_i,
        input  rx_data_i,
        input  rx_valid_i,
        output tx_data_o,
        output tx_load_o
    );

    modport master (
        output ssn_i,
        output rx_data_i,
        output rx_valid_i,
        input  tx_data_o,
        input  tx_load_o
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Command sequencer and register bank behind spi_device: frames the received byte
// stream into a command byte plus data bytes, executing burst writes and burst reads.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00,
    parameter logic [7:0]  STATUS_B  = 8'hA5
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    spi_reg_ctrl_if.slave               spi,
    output logic [8*(2**ADDR_W)-1:0]    regs_o,
    output logic                        wr_stb_o,
    output logic [ADDR_W-1:0]           wr_addr_o,
    output logic                        busy_o
);

    localparam int unsigned NREGS = 2**ADDR_W;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        CMD,
        WR,
        RD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        txData_q, txData_d;
    logic              txLoad_q, txLoad_d;
    logic              wrStb_q, wrStb_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        regs_q [NREGS];
    logic              regWe;
    logic [ADDR_W-1:0] cmdAddr;
    logic              rxByte;

    assign cmdAddr = spi.rx_data_i[ADDR_W-1:0];
    // A byte arriving together with the chip-select release is dropped.
    assign rxByte  = spi.rx_valid_i && !spi.ssn_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: begin
                if (spi.ssn_i) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!spi.ssn_i) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (spi.ssn_i) begin
                    state_d = IDLE;
                end else if (spi.rx_valid_i) begin
                    state_d = spi.rx_data_i[7] ? WR : RD;
                end
            end
            WR, RD: begin
                if (spi.ssn_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        txData_d = txData_q;
        txLoad_d = 1'b0;
        wrStb_d  = 1'b0;
        wrAddr_d = wrAddr_q;
        regWe    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!spi.ssn_i) begin
                    txData_d = STATUS_B;
                    txLoad_d = 1'b1;
                end
            end
            CMD: begin
                if (rxByte) begin
                    if (spi.rx_data_i[7]) begin
                        addr_d = cmdAddr;
                    end else begin
                        // Read bursts answer the command byte itself with the first register.
                        txData_d = regs_q[cmdAddr];
                        txLoad_d = 1'b1;
                        addr_d   = cmdAddr + ADDR_W'(1);
                    end
                end
            end
            WR: begin
                if (rxByte) begin
                    regWe    = 1'b1;
                    wrStb_d  = 1'b1;
                    wrAddr_d = addr_q;
                    addr_d   = addr_q + ADDR_W'(1);
                end
            end
            RD: begin
                if (rxByte) begin
                    txData_d = regs_q[addr_q];
                    txLoad_d = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            addr_q   <= '0;
            txData_q <= 8'h00;
            txLoad_q <= 1'b0;
            wrStb_q  <= 1'b0;
            wrAddr_q <= '0;
        end else begin
            addr_q   <= addr_d;
            txData_q <= txData_d;
            txLoad_q <= txLoad_d;
            wrStb_q  <= wrStb_d;
            wrAddr_q <= wrAddr_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (regWe) begin
            regs_q[addr_q] <= spi.rx_data_i;
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_o[8*k +: 8] = regs_q[k];
    end

    assign spi.tx_data_o = txData_q;
    assign spi.tx_load_o = txLoad_q;
    assign wr_stb_o      = wrStb_q;
    assign wr_addr_o     = wrAddr_q;
    assign busy_o        = (state_q == CMD) || (state_q == WR) || (state_q == RD);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames followed by random frames,
// all checked against a byte-level register model.
module tb_spi_reg_ctrl;

    localparam int NREGS = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] regs;
    logic         wrStb;
    logic [3:0]   wrAddr;
    logic         busy;

    always #5 clk = ~clk;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl #(
        .ADDR_W   (4),
        .RESET_VAL(8'h00),
        .STATUS_B (8'hA5)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .spi      (bus.slave),
        .regs_o   (regs),
        .wr_stb_o (wrStb),
        .wr_addr_o(wrAddr),
        .busy_o   (busy)
    );

    logic [7:0] model [NREGS];
    int         checks = 0;
    int         errors = 0;
    bit         frameWrite;
    int         frameStart;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] modelFlat();
        logic [127:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput("gap_load", bus.tx_load_o, 1'b0);
            checkOutput("gap_stb", wrStb, 1'b0);
        end
    endtask

    task automatic startFrame();
        bus.ssn_i = 1'b0;
        tick();
        checkOutput("start_load", bus.tx_load_o, 1'b1);
        checkOutput("start_data", bus.tx_data_o, 8'hA5);
        checkOutput("start_busy", busy, 1'b1);
        checkOutput("start_stb", wrStb, 1'b0);
    endtask

    // Byte k of the current frame (k = 0 is the command byte).
    task automatic applyStimulus(input logic [7:0] b, input int k);
        bit         expLoad;
        bit         expStb;
        logic [7:0] expData;
        int         a;
        expLoad = 1'b0;
        expStb  = 1'b0;
        expData = 8'h00;
        a       = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
        if (k == 0) begin
            frameWrite = b[7];
            frameStart = int'(b[3:0]);
            if (!frameWrite) begin
                expLoad = 1'b1;
                expData = model[frameStart];
            end
        end else if (frameWrite) begin
            a        = (frameStart + k - 1) % NREGS;
            model[a] = b;
            expStb   = 1'b1;
        end else begin
            a       = (frameStart + k) % NREGS;
            expLoad = 1'b1;
            expData = model[a];
        end
        checkOutput("byte_load", bus.tx_load_o, expLoad);
        checkOutput("byte_stb", wrStb, expStb);
        checkOutput("byte_busy", busy, 1'b1);
        if (expLoad) checkOutput("byte_txdata", bus.tx_data_o, expData);
        if (expStb) checkOutput("byte_wraddr", wrAddr, a[3:0]);
        checkOutput("byte_regs", regs, modelFlat());
    endtask

    task automatic endFrame(input bit collide, input logic [7:0] b);
        bus.ssn_i      = 1'b1;
        bus.rx_valid_i = collide;
        bus.rx_data_i  = b;
        tick();
        bus.rx_valid_i = 1'b0;
        checkOutput("end_load", bus.tx_load_o, 1'b0);
        checkOutput("end_stb", wrStb, 1'b0);
        checkOutput("end_busy", busy, 1'b0);
        checkOutput("end_regs", regs, modelFlat());
    endtask

    // A byte strobe the controller must ignore (outside a valid frame).
    task automatic ignoredByte(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
        checkOutput("ign_load", bus.tx_load_o, 1'b0);
        checkOutput("ign_stb", wrStb, 1'b0);
        checkOutput("ign_busy", busy, 1'b0);
        checkOutput("ign_regs", regs, modelFlat());
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r2;
        int         nData;
        bit         coll;
        logic [7:0] cmd;

        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
        bus.ssn_i      = 1'b1;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;

        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_regs", regs, 128'h0);
        checkOutput("rst_load", bus.tx_load_o, 1'b0);
        checkOutput("rst_txdata", bus.tx_data_o, 8'h00);
        checkOutput("rst_stb", wrStb, 1'b0);
        checkOutput("rst_wraddr", wrAddr, 4'h0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("sync_busy", busy, 1'b0);
        ignoredByte(8'h8A);

        // Write burst to reg3/reg4.
        startFrame();
        idleCycles(1);
        applyStimulus(8'h83, 0);
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 2);
        checkOutput("wr_reg3", regs[8*3 +: 8], 8'h11);
        checkOutput("wr_reg4", regs[8*4 +: 8], 8'h22);
        endFrame(1'b0, 8'h00);

        // Preload reg15/reg0 via a wrapping write, then a wrapping read.
        startFrame();
        applyStimulus(8'h8F, 0);
        applyStimulus(8'h5A, 1);
        applyStimulus(8'hC3, 2);
        endFrame(1'b0, 8'h00);
        startFrame();
        applyStimulus(8'h0F, 0);
        checkOutput("rd_first", bus.tx_data_o, 8'h5A);
        idleCycles(1);
        applyStimulus(8'h00, 1);
        checkOutput("rd_wrap", bus.tx_data_o, 8'hC3);
        applyStimulus(8'hFF, 2);
        endFrame(1'b0, 8'h00);

        // Abort after command, then a complete frame.
        startFrame();
        applyStimulus(8'h85, 0);
        endFrame(1'b0, 8'h00);
        startFrame();
        applyStimulus(8'h85, 0);
        applyStimulus(8'h77, 1);
        endFrame(1'b0, 8'h00);
        checkOutput("abort_reg5", regs[8*5 +: 8], 8'h77);

        // Collision of the last byte with chip-select release at addr 2.
        r2 = regs[8*2 +: 8];
        startFrame();
        applyStimulus(8'h82, 0);
        endFrame(1'b1, 8'h99);
        checkOutput("coll_reg2", regs[8*2 +: 8], r2);

        // Reset in the middle of a write frame; the frame left running must be ignored.
        startFrame();
        applyStimulus(8'h81, 0);
        applyStimulus(8'h10, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
        checkOutput("mrst_regs", regs, 128'h0);
        checkOutput("mrst_busy", busy, 1'b0);
        ignoredByte(8'h81);
        ignoredByte(8'h44);
        checkOutput("mrst_reg1", regs[8*1 +: 8], 8'h00);
        bus.ssn_i = 1'b1;
        tick();
        checkOutput("mrst_idle_busy", busy, 1'b0);
        startFrame();
        applyStimulus(8'h81, 0);
        applyStimulus(8'h44, 1);
        endFrame(1'b0, 8'h00);
        checkOutput("mrst_new_reg1", regs[8*1 +: 8], 8'h44);

        // Random frames.
        for (int f = 0; f < 60; f++) begin
            startFrame();
            idleCycles($urandom_range(0, 2));
            cmd = 8'($urandom);
            applyStimulus(cmd, 0);
            nData = $urandom_range(0, 6);
            for (int k = 1; k <= nData; k++) begin
                idleCycles($urandom_range(0, 2));
                applyStimulus(8'($urandom), k);
            end
            coll = ($urandom_range(0, 3) == 0);
            endFrame(coll, 8'($urandom));
            if ($urandom_range(0, 3) == 0) ignoredByte(8'($urandom));
            idleCycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
